// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, index type and zero-register constant for the register file
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 2;

   typedef logic [ADDR_W_DEF-1:0] regIdx_t;

   localparam regIdx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/write/reserve bus between the datapath and the register file
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   localparam int DEPTH = 2**ADDR_W;

   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rsv_ok;
   logic [DEPTH-1:0]  busy_vec;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ok, busy_vec
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ok, busy_vec
   );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with bypass, zero-register override and busy masking
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0]                  rdAddr,
   input  logic [2**ADDR_W-1:0][DATA_W-1:0]   storage,
   input  logic [2**ADDR_W-1:0]               busy,
   input  logic                               wrLive,
   input  logic [ADDR_W-1:0]                  wrAddr,
   input  logic [DATA_W-1:0]                  wrData,
   output logic [DATA_W-1:0]                  rdData,
   output logic                               rdBusy
);

   logic bypassHit;
   logic zeroHit;

   // wrLive already excludes reset and dropped zero-register writes, so a hit here always carries real data
   always_comb begin
      bypassHit = (BYPASS != 0) && wrLive && (wrAddr == rdAddr);
      zeroHit   = (ZERO_REG != 0) && (rdAddr == ADDR_W'(REG_ZERO));
      rdData    = storage[rdAddr];
      rdBusy    = busy[rdAddr];
      if (zeroHit) begin
         rdData = '0;
      end else if (bypassHit) begin
         rdData = wrData;
         rdBusy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass, optional zero register and busy scoreboard
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic         clk,
   input  logic         reset,
   regfile_sb_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] storage;
   logic [DEPTH-1:0]             busy;
   logic [DEPTH-1:0]             busyNext;
   logic                         wrLive;
   logic                         wrDrop;
   logic                         rsvOk;
   logic                         rsvSet;

   // Qualify write and reserve; reservation wins over a same-index writeback
   always_comb begin
      wrDrop = (ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(REG_ZERO));
      wrLive = bus.wr_en && !reset && !wrDrop;
      rsvOk  = bus.rsv_en && !reset &&
               (!busy[bus.rsv_addr] || (bus.wr_en && (bus.wr_addr == bus.rsv_addr)));
      rsvSet = rsvOk && !((ZERO_REG != 0) && (bus.rsv_addr == ADDR_W'(REG_ZERO)));
      busyNext = busy;
      if (bus.wr_en) begin
         busyNext[bus.wr_addr] = 1'b0;
      end
      if (rsvSet) begin
         busyNext[bus.rsv_addr] = 1'b1;
      end
   end

   // Storage and scoreboard update; reset clears everything and ignores the strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         storage <= '0;
         busy    <= '0;
      end else begin
         if (wrLive) begin
            storage[bus.wr_addr] <= bus.wr_data;
         end
         busy <= busyNext;
      end
   end

   regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) rdPort1 (
      .rdAddr  (bus.rd_addr1),
      .storage (storage),
      .busy    (busy),
      .wrLive  (wrLive),
      .wrAddr  (bus.wr_addr),
      .wrData  (bus.wr_data),
      .rdData  (bus.rd_data1),
      .rdBusy  (bus.rd_busy1)
   );

   regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) rdPort2 (
      .rdAddr  (bus.rd_addr2),
      .storage (storage),
      .busy    (busy),
      .wrLive  (wrLive),
      .wrAddr  (bus.wr_addr),
      .wrData  (bus.wr_data),
      .rdData  (bus.rd_data2),
      .rdBusy  (bus.rd_busy2)
   );

   assign bus.rsv_ok   = rsvOk;
   assign bus.busy_vec = busy;

endmodule
